demux3_32b: RTL and testbench
=============================

# demux3_32b

Registered 1-to-3 demultiplexer for 32-bit datapath words, the distribution counterpart of the 3-input 32-bit select mux. It steers one producer word to one of three consumer slots named by `control`. Each slot is a one-entry buffer with valid/ack handshake, so the producer stalls only when the addressed slot is occupied. It sits between a single result source (ALU/memory read path) and three destination stages that drain at independent rates.

## Interface
- `WIDTH`, 32, data word width.
- `DROP_CNT_W`, 8, width of the saturating drop counter.

- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  word offered by the producer.
- `in_valid`  in  1  producer has a word this cycle.
- `control`  in  2  destination: 00→slot 0, 01→slot 1, 10→slot 2, 11→drop.
- `in_ready`  out  1  word is accepted this cycle if `in_valid`=1.
- `out0`, `out1`, `out2`  out  WIDTH  slot data registers.
- `out_valid`  out  3  bit c = slot c holds an unconsumed word.
- `out_ack`  in  3  bit c = consumer c takes slot c's word this cycle.
- `err`  out  1  one-cycle pulse on an accepted word with `control`=11.
- `drop_cnt`  out  DROP_CNT_W  count of dropped words, saturating.

## Operation
- Decided: one clock; reset is asynchronous and active-high, ports `clk` and `rst`.
- Reset values: `out0..2`=0, `out_valid`=000, `err`=0, `drop_cnt`=0.
- `in_ready` is combinational from `control`, `out_valid` and `out_ack`.
  - `control`=c (0..2): `in_ready` = !out_valid[c] | out_ack[c].
  - `control`=11: `in_ready`=1 (drop is always accepted).
  - `in_ready` does not depend on `in_valid`.
- Accept = `in_valid` & `in_ready`.
- Accept to slot c: `out_c` <= `in_data`, `out_valid[c]` <= 1. Other slots are unchanged.
- Consume: `out_ack[c]` & `out_valid[c]` & no write to c → `out_valid[c]` <= 0. `out_c` keeps its last value (it is not cleared).
- Same-cycle ack and write on slot c: `out_valid[c]` stays 1, `out_c` takes the new word. No bubble; the slot sustains 1 word/cycle.
- `out_ack[c]` while `out_valid[c]`=0 is ignored, with no state change.
- Acks on different slots in the same cycle are all honoured independently.
- Accept with `control`=11: no slot is written, `err`=1 next cycle for exactly one cycle, `drop_cnt` += 1, saturating at 2^DROP_CNT_W−1.
- `control` and `in_data` are sampled only on accept. Changing them while stalled is legal; `in_ready` re-evaluates the same cycle.
- Reset asserted mid-operation clears all state immediately (async). Words in flight are lost; acks during reset are ignored.
- First clock edge after `rst` deasserts behaves as a normal cycle.

## Timing
- Latency: 1 cycle from accept edge to `out_valid[c]`=1 and `out_c` valid.
- Throughput: 1 word/cycle to any slot if its consumer acks every cycle, and 1 word/cycle to alternating free slots.
- `out_c`, `out_valid`, `err`, `drop_cnt` are registered. `in_ready` is the only combinational output (path from `control`/`out_ack`).
- `err` and the `drop_cnt` increment appear on the edge that accepts the drop.

## Structure
- Shared package `demux_pkg`:
  - constants `SEL_CH0`=2'b00, `SEL_CH1`=2'b01, `SEL_CH2`=2'b10, `SEL_DROP`=2'b11;
  - `NUM_CH`=3.
  - These are shared with the mux select encoding so both blocks decode the same control values.
- One natural sub-module, `demux_slot_32b`: a one-entry buffer with ports `clk`, `rst`, `wr_en`, `wr_data`, `ack`, `data`, `valid`, `free` (= !valid | ack).
  - The top instantiates it three times, plus the select decode, drop counter and `err` register.

## Test plan
- Reset, then `in_valid`=1, `control`=01, `in_data`=0x55555555 → next cycle `out_valid`=010, `out1`=0x55555555; `out0`, `out2`=0.
- Slot 0 full, no ack, `control`=00, `in_valid`=1 → `in_ready`=0 and `out0` holds. Assert `out_ack[0]` in the same cycle → `in_ready`=1; next cycle `out0` = new word, `out_valid[0]` still 1.
- Stream 0xFFFF0000, 0x00000001, 0x12345678 to slots 2, 0, 1 on consecutive cycles with no acks → all three accepted, `out_valid`=111, each slot holds its word.
- `control`=11 with `in_valid`=1 for 300 cycles → `err` pulses each cycle, `drop_cnt` saturates at 255, `out_valid` unchanged.
- Ack on an empty slot → no state change. Then `rst` pulse mid-cycle with `out_valid`=111 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/demux_pkg.sv
// Select encoding shared by the 3-input mux and the 1-to-3 demux so both decode
// the same control values.
package demux_pkg;

  localparam int NUM_CH = 3;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_CH0  = 2'b00;
  localparam sel_t SEL_CH1  = 2'b01;
  localparam sel_t SEL_CH2  = 2'b10;
  localparam sel_t SEL_DROP = 2'b11;

  function automatic logic is_drop(input sel_t sel);
    return sel == SEL_DROP;
  endfunction

endpackage

// File: rtl/demux_slot_32b.sv
// One-entry output buffer with valid/ack handshake; a write and an ack in the
// same cycle replace the word without a bubble.
module demux_slot_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en) begin
      data_d  = wr_data;
      valid_d = 1'b1;
    end else if (ack && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign free  = !valid_q || ack;

endmodule

// File: rtl/demux3_32b.sv
// Registered 1-to-3 demultiplexer: steers a producer word into one of three
// one-entry slots, or drops it (counted, flagged on err) when control selects drop.
module demux3_32b
  import demux_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  input  logic [1:0]            control,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out0,
  output logic [WIDTH-1:0]      out1,
  output logic [WIDTH-1:0]      out2,
  output logic [NUM_CH-1:0]     out_valid,
  input  logic [NUM_CH-1:0]     out_ack,
  output logic                  err,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] free;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  logic              drop_acc;

  logic                  err_q, err_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // in_ready deliberately ignores in_valid so the producer can look ahead.
  always_comb begin
    in_ready = 1'b1;
    wr_en    = '0;
    drop_acc = 1'b0;
    case (control)
      SEL_CH0: begin
        in_ready = free[0];
        wr_en[0] = in_valid && free[0];
      end
      SEL_CH1: begin
        in_ready = free[1];
        wr_en[1] = in_valid && free[1];
      end
      SEL_CH2: begin
        in_ready = free[2];
        wr_en[2] = in_valid && free[2];
      end
      default: begin
        in_ready = 1'b1;
        drop_acc = in_valid && is_drop(control);
      end
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    demux_slot_32b #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en[c]),
      .wr_data(in_data),
      .ack    (out_ack[c]),
      .data   (slot_data[c]),
      .valid  (out_valid[c]),
      .free   (free[c])
    );
  end

  always_comb begin
    err_d      = drop_acc;
    drop_cnt_d = drop_cnt_q;
    if (drop_acc && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out0     = slot_data[0];
  assign out1     = slot_data[1];
  assign out2     = slot_data[2];
  assign err      = err_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux3_32b.sv
// Scoreboard bench for demux3_32b: the driver pushes accepted words per slot,
// a negedge monitor peeks/pops them and checks err and drop_cnt against a model.
module tb_demux3_32b;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic [1:0]  control;
  logic        in_ready;
  logic [31:0] out0, out1, out2;
  logic [2:0]  out_valid;
  logic [2:0]  out_ack;
  logic        err;
  logic [7:0]  drop_cnt;

  demux3_32b dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .control  (control),
    .in_ready (in_ready),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out_valid(out_valid),
    .out_ack  (out_ack),
    .err      (err),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic run = 1'b0;

  // Reference model: per-slot contents as queues, drop bookkeeping as integers.
  logic [31:0] exp_q [3][$];
  logic        exp_err = 1'b0;
  int          exp_cnt = 0;
  logic        pend_wr = 1'b0;
  int          pend_ch = 0;
  logic [31:0] pend_data = '0;
  logic        pend_drop = 1'b0;

  logic [31:0] outs [3];
  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: commit last cycle's accept into the model, drive, check in_ready.
  task automatic cyc(input logic v, input logic [1:0] ctl, input logic [31:0] d,
                     input logic [2:0] ack);
    logic exp_rdy;
    @(posedge clk);
    #1;
    if (pend_wr) exp_q[pend_ch].push_back(pend_data);
    exp_err = pend_drop;
    if (pend_drop && exp_cnt < 255) exp_cnt++;
    pend_wr   = 1'b0;
    pend_drop = 1'b0;
    in_valid = v;
    control  = ctl;
    in_data  = d;
    out_ack  = ack;
    #1;
    if (ctl == 2'd3) exp_rdy = 1'b1;
    else exp_rdy = (exp_q[ctl].size() == 0) || ack[ctl];
    chk("in_ready", in_ready, exp_rdy);
    if (v && exp_rdy) begin
      if (ctl == 2'd3) pend_drop = 1'b1;
      else begin
        pend_wr   = 1'b1;
        pend_ch   = int'(ctl);
        pend_data = d;
      end
    end
  endtask

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("err", err, exp_err);
      chk("drop_cnt", drop_cnt, exp_cnt);
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("out_valid[%0d]", c), out_valid[c], exp_q[c].size() != 0);
        if (exp_q[c].size() != 0) begin
          chk($sformatf("out%0d", c), outs[c], exp_q[c][0]);
          if (out_ack[c]) void'(exp_q[c].pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    control = 2'd0;
    in_data = '0;
    out_ack = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out0", out0, 0);
    chk("rst out1", out1, 0);
    chk("rst out2", out2, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst err", err, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    run = 1'b1;

    // Single write to slot 1.
    cyc(1, 2'd1, 32'h5555_5555, 3'b000);
    cyc(0, 2'd0, 32'h0, 3'b000);
    chk("t1 out_valid", out_valid, 3'b010);
    chk("t1 out1", out1, 32'h5555_5555);
    chk("t1 out0", out0, 0);
    chk("t1 out2", out2, 0);

    // Slot 0 full: stall, then write-through with same-cycle ack.
    cyc(1, 2'd0, 32'hAAAA_0001, 3'b000);
    cyc(1, 2'd0, 32'hBBBB_0002, 3'b000);
    cyc(1, 2'd0, 32'hBBBB_0002, 3'b001);
    cyc(0, 2'd0, 32'h0, 3'b000);
    chk("t2 out0", out0, 32'hBBBB_0002);
    chk("t2 out_valid0", out_valid[0], 1'b1);

    // Drain, then ack on empty slots must change nothing.
    cyc(0, 2'd0, 32'h0, 3'b111);
    cyc(0, 2'd0, 32'h0, 3'b111);
    chk("t3 out0 kept", out0, 32'hBBBB_0002);
    chk("t3 out1 kept", out1, 32'h5555_5555);

    // Back-to-back stream to slots 2, 0, 1.
    cyc(1, 2'd2, 32'hFFFF_0000, 3'b000);
    cyc(1, 2'd0, 32'h0000_0001, 3'b000);
    cyc(1, 2'd1, 32'h1234_5678, 3'b000);
    cyc(0, 2'd0, 32'h0, 3'b000);
    chk("t4 out_valid", out_valid, 3'b111);
    chk("t4 out2", out2, 32'hFFFF_0000);
    chk("t4 out0", out0, 32'h0000_0001);
    chk("t4 out1", out1, 32'h1234_5678);

    // 300 drops: counter saturates, slots untouched.
    for (int i = 0; i < 300; i++) cyc(1, 2'd3, $urandom, 3'b000);
    cyc(0, 2'd0, 32'h0, 3'b000);
    chk("t5 drop_cnt sat", drop_cnt, 8'd255);
    chk("t5 out_valid", out_valid, 3'b111);

    // Async reset in the middle of the low phase, acks held during reset.
    #1;
    rst = 1'b1;
    out_ack = 3'b111;
    in_valid = 1'b1;
    #1;
    chk("arst out_valid", out_valid, 0);
    chk("arst out0", out0, 0);
    chk("arst out1", out1, 0);
    chk("arst out2", out2, 0);
    chk("arst drop_cnt", drop_cnt, 0);
    for (int c = 0; c < 3; c++) exp_q[c].delete();
    exp_err = 1'b0;
    exp_cnt = 0;
    pend_wr = 1'b0;
    pend_drop = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ack = 3'b000;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
          3'($urandom));
    end
    repeat (3) cyc(0, 2'd0, 32'h0, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
